// File: rtl/tm_tape_ctrl.sv
// Tape-head controller: keeps the head position and a one-cell symbol cache.
// It turns core READ / WRITE+MOVE commands into single-byte SRAM requests.
module tm_tape_ctrl #(
    parameter int              HEAD_W    = 12,
    parameter logic [15:0]     BASE_ADDR = 16'h0100,
    parameter logic [HEAD_W-1:0] HEAD_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_op_i,
    input  logic [7:0]        cmd_sym_i,
    input  logic [1:0]        cmd_move_i,
    output logic              rsp_valid_o,
    output logic [7:0]        rsp_sym_o,
    output logic [HEAD_W-1:0] head_o,
    output logic              mem_valid_o,
    output logic              mem_iswr_o,
    output logic [15:0]       mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic              mem_done_i,
    input  logic [7:0]        mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, RESP} state_t;

    state_t            state_reg, state_next;
    logic [HEAD_W-1:0] head_reg, head_next;
    logic [7:0]        cache_reg, cache_next;
    logic              cache_valid_reg, cache_valid_next;
    logic [1:0]        move_reg, move_next;
    logic              mem_valid_reg, mem_valid_next;
    logic              mem_iswr_reg, mem_iswr_next;
    logic [15:0]       mem_addr_reg, mem_addr_next;
    logic [7:0]        mem_wdata_reg, mem_wdata_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [7:0]        rsp_sym_reg, rsp_sym_next;
    logic [15:0]       head_addr;
    logic              is_stay;

    function automatic logic [HEAD_W-1:0] apply_move(input logic [HEAD_W-1:0] h,
                                                     input logic [1:0] mv);
        case (mv)
            2'b01:   return h - HEAD_W'(1);
            2'b10:   return h + HEAD_W'(1);
            default: return h;
        endcase
    endfunction

    assign head_addr = BASE_ADDR + 16'(head_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            head_reg        <= HEAD_INIT;
            cache_reg       <= 8'h00;
            cache_valid_reg <= 1'b0;
            move_reg        <= 2'b00;
            mem_valid_reg   <= 1'b0;
            mem_iswr_reg    <= 1'b0;
            mem_addr_reg    <= 16'h0000;
            mem_wdata_reg   <= 8'h00;
            rsp_valid_reg   <= 1'b0;
            rsp_sym_reg     <= 8'h00;
        end else begin
            state_reg       <= state_next;
            head_reg        <= head_next;
            cache_reg       <= cache_next;
            cache_valid_reg <= cache_valid_next;
            move_reg        <= move_next;
            mem_valid_reg   <= mem_valid_next;
            mem_iswr_reg    <= mem_iswr_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_sym_reg     <= rsp_sym_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        head_next        = head_reg;
        cache_next       = cache_reg;
        cache_valid_next = cache_valid_reg;
        move_next        = move_reg;
        mem_valid_next   = mem_valid_reg;
        mem_iswr_next    = mem_iswr_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        rsp_valid_next   = 1'b0;
        rsp_sym_next     = rsp_sym_reg;
        is_stay          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (!cmd_op_i) begin
                        if (cache_valid_reg) begin
                            state_next     = RESP;
                            rsp_valid_next = 1'b1;
                            rsp_sym_next   = cache_reg;
                        end else begin
                            state_next     = RD_REQ;
                            mem_valid_next = 1'b1;
                            mem_iswr_next  = 1'b0;
                            mem_addr_next  = head_addr;
                        end
                    end else if (cache_valid_reg && cache_reg == cmd_sym_i) begin
                        // Cell already holds this symbol: skip the SRAM write.
                        is_stay        = (cmd_move_i == 2'b00) || (cmd_move_i == 2'b11);
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_sym_next   = cmd_sym_i;
                        head_next      = apply_move(head_reg, cmd_move_i);
                        if (!is_stay) begin
                            cache_valid_next = 1'b0;
                        end
                    end else begin
                        state_next     = WR_REQ;
                        mem_valid_next = 1'b1;
                        mem_iswr_next  = 1'b1;
                        mem_addr_next  = head_addr;
                        mem_wdata_next = cmd_sym_i;
                        move_next      = cmd_move_i;
                    end
                end
            end
            RD_REQ: begin
                if (mem_done_i) begin
                    state_next       = RESP;
                    mem_valid_next   = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_sym_next     = mem_rdata_i;
                    cache_next       = mem_rdata_i;
                    cache_valid_next = 1'b1;
                end
            end
            WR_REQ: begin
                if (mem_done_i) begin
                    is_stay          = (move_reg == 2'b00) || (move_reg == 2'b11);
                    state_next       = RESP;
                    mem_valid_next   = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_sym_next     = mem_wdata_reg;
                    head_next        = apply_move(head_reg, move_reg);
                    cache_next       = mem_wdata_reg;
                    cache_valid_next = is_stay;
                end
            end
            default: begin
                // RESP lasts one cycle, which also forces a low cycle of mem_valid_o.
                state_next     = IDLE;
                mem_valid_next = 1'b0;
            end
        endcase
    end

    assign cmd_ready_o = (state_reg == IDLE);
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_sym_o   = rsp_sym_reg;
    assign head_o      = head_reg;
    assign mem_valid_o = mem_valid_reg;
    assign mem_iswr_o  = mem_iswr_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;

endmodule

// File: tb/tb_tm_tape_ctrl.sv
// Directed bench for tm_tape_ctrl: expected response symbols go into a queue
// when a command or memory completion is driven and are popped on rsp_valid_o.
module tb_tm_tape_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_op_i = 1'b0;
    logic [7:0]  cmd_sym_i = 8'h00;
    logic [1:0]  cmd_move_i = 2'b00;
    logic        rsp_valid_o;
    logic [7:0]  rsp_sym_o;
    logic [11:0] head_o;
    logic        mem_valid_o;
    logic        mem_iswr_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_done_i = 1'b0;
    logic [7:0]  mem_rdata_i = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    tm_tape_ctrl #(.HEAD_W(12), .BASE_ADDR(16'h0100), .HEAD_INIT(12'h000)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_sym_i(cmd_sym_i), .cmd_move_i(cmd_move_i),
        .rsp_valid_o(rsp_valid_o), .rsp_sym_o(rsp_sym_o), .head_o(head_o),
        .mem_valid_o(mem_valid_o), .mem_iswr_o(mem_iswr_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic [7:0] sym, input logic [1:0] mv);
        check("ready_before_cmd", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_sym_i   = sym;
        cmd_move_i  = mv;
        tick();
        cmd_valid_i = 1'b0;
        $display("cmd op=%0d sym=%02h move=%0d head=%03h", op, sym, mv, head_o);
    endtask

    task automatic mem_done(input logic [7:0] rdata);
        mem_done_i  = 1'b1;
        mem_rdata_i = rdata;
        tick();
        mem_done_i  = 1'b0;
        mem_rdata_i = 8'h00;
    endtask

    // Response monitor: every rsp_valid_o pulse must match the oldest queued symbol.
    always begin
        @(posedge clk);
        #1;
        if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("rsp_sym", 32'(rsp_sym_o), 32'(e));
                $display("rsp sym=%02h expected=%02h", rsp_sym_o, e);
            end
        end
    end

    initial begin
        // T1 reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        check("rst_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_head", 32'(head_o), 32'd0);
        check("rst_addr", 32'(mem_addr_o), 32'd0);

        // T2 read miss at head 0
        send(1'b0, 8'h00, 2'b00);
        check("t2_mem_valid", 32'(mem_valid_o), 32'd1);
        check("t2_iswr", 32'(mem_iswr_o), 32'd0);
        check("t2_addr", 32'(mem_addr_o), 32'h0100);
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        cmd_valid_i = 1'b0;
        check("t2_ready_busy", 32'(cmd_ready_o), 32'd0);
        check("t2_mem_valid_held", 32'(mem_valid_o), 32'd1);
        check("t2_addr_held", 32'(mem_addr_o), 32'h0100);
        exp_q.push_back(8'h5A);
        mem_done(8'h5A);
        check("t2_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("t2_rsp_sym", 32'(rsp_sym_o), 32'h5A);
        check("t2_mem_valid_low", 32'(mem_valid_o), 32'd0);
        tick();
        check("t2_rsp_one_cycle", 32'(rsp_valid_o), 32'd0);

        // T3 cache hit
        exp_q.push_back(8'h5A);
        send(1'b0, 8'h00, 2'b00);
        check("t3_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("t3_no_mem", 32'(mem_valid_o), 32'd0);
        tick();

        // T4 write 0x31 move right
        send(1'b1, 8'h31, 2'b10);
        check("t4_mem_valid", 32'(mem_valid_o), 32'd1);
        check("t4_iswr", 32'(mem_iswr_o), 32'd1);
        check("t4_wdata", 32'(mem_wdata_o), 32'h31);
        check("t4_addr", 32'(mem_addr_o), 32'h0100);
        tick();
        tick();
        exp_q.push_back(8'h31);
        mem_done(8'hEE);
        check("t4_head", 32'(head_o), 32'd1);
        check("t4_rsp_sym", 32'(rsp_sym_o), 32'h31);
        tick();
        send(1'b0, 8'h00, 2'b00);
        check("t4_read_miss", 32'(mem_valid_o), 32'd1);
        check("t4_read_addr", 32'(mem_addr_o), 32'h0101);
        exp_q.push_back(8'h77);
        mem_done(8'h77);
        tick();

        // Skipped write with move: back to head 0, cache invalidated
        exp_q.push_back(8'h77);
        send(1'b1, 8'h77, 2'b01);
        check("skipmv_no_mem", 32'(mem_valid_o), 32'd0);
        check("skipmv_rsp", 32'(rsp_valid_o), 32'd1);
        check("skipmv_head", 32'(head_o), 32'd0);
        tick();
        send(1'b0, 8'h00, 2'b00);
        check("skipmv_miss", 32'(mem_valid_o), 32'd1);
        check("skipmv_addr", 32'(mem_addr_o), 32'h0100);
        exp_q.push_back(8'h5A);
        mem_done(8'h5A);
        tick();

        // T5 redundant write stay, then redundant write left from 0
        exp_q.push_back(8'h5A);
        send(1'b1, 8'h5A, 2'b00);
        check("t5_no_mem", 32'(mem_valid_o), 32'd0);
        check("t5_rsp", 32'(rsp_valid_o), 32'd1);
        check("t5_head", 32'(head_o), 32'd0);
        tick();
        exp_q.push_back(8'h5A);
        send(1'b1, 8'h5A, 2'b01);
        check("t5l_no_mem", 32'(mem_valid_o), 32'd0);
        check("t5l_head_wrap", 32'(head_o), 32'hFFF);
        tick();
        send(1'b0, 8'h00, 2'b00);
        check("t5l_miss", 32'(mem_valid_o), 32'd1);
        check("t5l_addr", 32'(mem_addr_o), 32'h10FF);
        exp_q.push_back(8'h11);
        mem_done(8'h11);
        tick();

        // Right from max wraps to 0
        send(1'b1, 8'h22, 2'b10);
        check("wrap_iswr", 32'(mem_iswr_o), 32'd1);
        check("wrap_addr", 32'(mem_addr_o), 32'h10FF);
        exp_q.push_back(8'h22);
        mem_done(8'h00);
        check("wrap_head", 32'(head_o), 32'd0);
        tick();

        // Write with stay fills the cache
        send(1'b1, 8'h44, 2'b00);
        check("wst_mem_valid", 32'(mem_valid_o), 32'd1);
        exp_q.push_back(8'h44);
        mem_done(8'h00);
        tick();
        exp_q.push_back(8'h44);
        send(1'b0, 8'h00, 2'b00);
        check("wst_hit_no_mem", 32'(mem_valid_o), 32'd0);
        check("wst_hit_rsp", 32'(rsp_valid_o), 32'd1);
        tick();

        // T6 reset during RD_REQ from head 1
        exp_q.push_back(8'h44);
        send(1'b1, 8'h44, 2'b10);
        check("t6_head1", 32'(head_o), 32'd1);
        tick();
        send(1'b0, 8'h00, 2'b00);
        check("t6_rdreq", 32'(mem_valid_o), 32'd1);
        check("t6_rd_addr", 32'(mem_addr_o), 32'h0101);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_mem_valid", 32'(mem_valid_o), 32'd0);
        check("t6_ready", 32'(cmd_ready_o), 32'd1);
        check("t6_head", 32'(head_o), 32'd0);
        mem_done(8'h99);
        check("t6_no_rsp", 32'(rsp_valid_o), 32'd0);
        tick();
        check("t6_no_rsp2", 32'(rsp_valid_o), 32'd0);
        check("t6_idle", 32'(cmd_ready_o), 32'd1);
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
